// File: rtl/otsu_binarizer.sv
// otsu_binarizer: applies a per-frame latched Otsu threshold to a pixel stream
// and publishes per-frame foreground/valid pixel counts at each VS falling edge.
module otsu_binarizer #(
  parameter bit          INVERT     = 1'b0,
  parameter int          CNT_W      = 19,
  parameter logic [7:0]  INIT_LEVEL = 8'd128
) (
  input  logic             iClk,
  input  logic             reset,
  input  logic             VS,
  input  logic             VGA_Read,
  input  logic [7:0]       Valor_Pixel,
  input  logic [7:0]       Level,
  output logic [7:0]       Pixel_Bin,
  output logic             Bin_Valid,
  output logic [7:0]       Level_Used,
  output logic [CNT_W-1:0] Fg_Count,
  output logic [CNT_W-1:0] Px_Count,
  output logic             Frame_Done
);
  logic             vs_d, fall, v1, fg1, fg_next, inc_fg;
  logic [CNT_W-1:0] acc_fg, acc_px, sum_fg, sum_px;
  assign fall    = vs_d & ~VS;
  assign fg_next = INVERT ? Valor_Pixel <= Level_Used : Valor_Pixel > Level_Used;
  assign inc_fg  = v1 & fg1;
  // Saturate rather than wrap so an oversized frame reads as "full", not small
  assign sum_fg  = &acc_fg ? acc_fg : acc_fg + CNT_W'(inc_fg);
  assign sum_px  = &acc_px ? acc_px : acc_px + CNT_W'(v1);
  always_ff @(posedge iClk) begin
    if (!reset) begin
      vs_d       <= 1'b1;
      v1         <= 1'b0;
      fg1        <= 1'b0;
      Pixel_Bin  <= 8'h00;
      Bin_Valid  <= 1'b0;
      Level_Used <= INIT_LEVEL;
      Fg_Count   <= '0;
      Px_Count   <= '0;
      acc_fg     <= '0;
      acc_px     <= '0;
      Frame_Done <= 1'b0;
    end else begin
      vs_d       <= VS;
      v1         <= VGA_Read;
      fg1        <= fg_next;
      Pixel_Bin  <= {8{fg1}};
      Bin_Valid  <= v1;
      Frame_Done <= fall;
      Level_Used <= fall ? Level : Level_Used;
      Fg_Count   <= fall ? acc_fg : Fg_Count;
      Px_Count   <= fall ? acc_px : Px_Count;
      // The pixel in flight at the boundary opens the new frame's tally
      acc_fg     <= fall ? CNT_W'(inc_fg) : sum_fg;
      acc_px     <= fall ? CNT_W'(v1) : sum_px;
    end
  end
endmodule
